// File: rtl/fifo_pkg.sv
// Shared width helpers for the multi-channel FIFO.
// The payload is generic, so only the pointer and count widths are derived here.
package fifo_pkg;

  // Pointer width: indexes DEPTH entries and wraps naturally at DEPTH-1 -> 0.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: must hold 0..DEPTH inclusive, one more state than the pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_chan.sv
// One first-word-fall-through FIFO channel.
// It has storage, read/write pointers, an occupancy count, sticky error flags and flag decode.
// Ports:
//   clk, arst_n       clock and synchronous active-low reset
//   flush             clears pointers, count and errors; overrides write/read
//   write, din        push request and data (accepted when full_n)
//   read              pop request (accepted when empty_n)
//   full_n            channel can accept a write
//   almost_full_n     count < DEPTH-AF_MARGIN
//   empty_n, dout     head entry valid / head entry (0 when empty)
//   count             occupancy 0..DEPTH
//   err_ovf, err_udf  sticky overflow / underflow
module fifo_chan
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_MARGIN  = 1
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      flush,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      read,
  output logic                      full_n,
  output logic                      almost_full_n,
  output logic                      empty_n,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      err_ovf,
  output logic                      err_udf
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  ovf_q;
  logic                  udf_q;

  // Flags come straight from the registered count, so they are glitch-free
  // relative to the current cycle's requests.
  assign full_n        = (cnt != FULL_LEVEL);
  assign empty_n       = (cnt != '0);
  assign almost_full_n = (cnt < AF_LEVEL);
  assign dout          = empty_n ? mem[rd_ptr] : '0;
  assign count         = cnt;
  assign err_ovf       = ovf_q;
  assign err_udf       = udf_q;

  logic wr_acc;
  logic rd_acc;
  assign wr_acc = write && full_n;
  assign rd_acc = read && empty_n;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!arst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (write && !full_n) ovf_q <= 1'b1;
      // A read on an empty channel is only an underflow when it is not paired
      // with an accepted write; in that case it is simply gated by empty_n.
      if (read && !empty_n && !wr_acc) udf_q <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the count and pointers alone decide which
  // entries are meaningful, and dout is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (arst_n && !flush && wr_acc) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fifo_multi_cnt.sv
// M independent FWFT FIFO channels with per-channel count, almost-full, flush
// and sticky error flags. Every port is an unpacked array indexed by channel.
// Ports (per channel [0:M-1]):
//   flush, write, din, read                inputs
//   full_n, almost_full_n, empty_n, dout   status / head data
//   count, err_ovf, err_udf                occupancy and sticky errors
//   clk, arst_n                            shared clock and synchronous active-low reset
module fifo_multi_cnt
  import fifo_pkg::*;
#(
  parameter int M          = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_MARGIN  = 1,
  localparam int CW        = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  flush         [0:M-1],
  output logic                  full_n        [0:M-1],
  output logic                  almost_full_n [0:M-1],
  input  logic                  write         [0:M-1],
  input  logic [DATA_WIDTH-1:0] din           [0:M-1],
  output logic                  empty_n       [0:M-1],
  input  logic                  read          [0:M-1],
  output logic [DATA_WIDTH-1:0] dout          [0:M-1],
  output logic [CW-1:0]         count         [0:M-1],
  output logic                  err_ovf       [0:M-1],
  output logic                  err_udf       [0:M-1]
);

  for (genvar i = 0; i < M; i++) begin : g_chan
    fifo_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AF_MARGIN  (AF_MARGIN)
    ) u_chan (
      .clk           (clk),
      .arst_n        (arst_n),
      .flush         (flush[i]),
      .write         (write[i]),
      .din           (din[i]),
      .read          (read[i]),
      .full_n        (full_n[i]),
      .almost_full_n (almost_full_n[i]),
      .empty_n       (empty_n[i]),
      .dout          (dout[i]),
      .count         (count[i]),
      .err_ovf       (err_ovf[i]),
      .err_udf       (err_udf[i])
    );
  end

endmodule

// File: tb/tb_fifo_multi_cnt.sv
module tb_fifo_multi_cnt;

  localparam int M     = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AFM   = 1;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          flush   [0:M-1];
  logic          full_n  [0:M-1];
  logic          afull_n [0:M-1];
  logic          write   [0:M-1];
  logic [DW-1:0] din     [0:M-1];
  logic          empty_n [0:M-1];
  logic          read    [0:M-1];
  logic [DW-1:0] dout    [0:M-1];
  logic [CW-1:0] count   [0:M-1];
  logic          err_ovf [0:M-1];
  logic          err_udf [0:M-1];

  fifo_multi_cnt #(.M(M), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .flush         (flush),
    .full_n        (full_n),
    .almost_full_n (afull_n),
    .write         (write),
    .din           (din),
    .empty_n       (empty_n),
    .read          (read),
    .dout          (dout),
    .count         (count),
    .err_ovf       (err_ovf),
    .err_udf       (err_udf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected contents per channel plus expected sticky errors.
  logic [DW-1:0] sb [M][$];
  logic          m_ovf [M];
  logic          m_udf [M];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_chan(input int ch);
    int n;
    n = sb[ch].size();
    check($sformatf("ch%0d count", ch),   32'(count[ch]),   32'(n));
    check($sformatf("ch%0d full_n", ch),  32'(full_n[ch]),  32'(n != DEPTH));
    check($sformatf("ch%0d afull_n", ch), 32'(afull_n[ch]), 32'(n < DEPTH - AFM));
    check($sformatf("ch%0d empty_n", ch), 32'(empty_n[ch]), 32'(n != 0));
    check($sformatf("ch%0d dout", ch),    32'(dout[ch]),    (n != 0) ? 32'(sb[ch][0]) : 32'd0);
    check($sformatf("ch%0d err_ovf", ch), 32'(err_ovf[ch]), 32'(m_ovf[ch]));
    check($sformatf("ch%0d err_udf", ch), 32'(err_udf[ch]), 32'(m_udf[ch]));
  endtask

  // Advance one clock: update the scoreboard from the inputs being driven,
  // compare popped data against dout, then sample outputs 1 time unit after the edge.
  task automatic tick();
    for (int ch = 0; ch < M; ch++) begin
      if (!arst_n || flush[ch]) begin
        sb[ch].delete();
        m_ovf[ch] = 1'b0;
        m_udf[ch] = 1'b0;
      end else begin
        bit full, empty, wacc, racc;
        full  = (sb[ch].size() == DEPTH);
        empty = (sb[ch].size() == 0);
        wacc  = write[ch] && !full;
        racc  = read[ch] && !empty;
        if (write[ch] && full) m_ovf[ch] = 1'b1;
        if (read[ch] && empty && !wacc) m_udf[ch] = 1'b1;
        if (racc) check($sformatf("ch%0d pop", ch), 32'(dout[ch]), 32'(sb[ch].pop_front()));
        if (wacc) sb[ch].push_back(din[ch]);
      end
    end
    @(posedge clk);
    #1;
    for (int ch = 0; ch < M; ch++) check_chan(ch);
  endtask

  task automatic idle();
    for (int ch = 0; ch < M; ch++) begin
      flush[ch] = 1'b0;
      write[ch] = 1'b0;
      read[ch]  = 1'b0;
      din[ch]   = '0;
    end
  endtask

  task automatic push(input int ch, input logic [DW-1:0] d);
    idle();
    write[ch] = 1'b1;
    din[ch]   = d;
    tick();
  endtask

  task automatic pop(input int ch);
    idle();
    read[ch] = 1'b1;
    tick();
  endtask

  initial begin
    for (int ch = 0; ch < M; ch++) begin
      m_ovf[ch] = 1'b0;
      m_udf[ch] = 1'b0;
    end
    idle();

    // 1. Reset held for two cycles, then released.
    arst_n = 1'b0;
    @(posedge clk); #1;
    tick();
    arst_n = 1'b1;
    tick();

    // 2. Fill and drain ch0; ch1 stays idle.
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    check("fill afull_n at 3", 32'(afull_n[0]), 32'd0);
    check("fill full_n at 3", 32'(full_n[0]), 32'd1);
    push(0, 8'h44);
    check("fill full_n at 4", 32'(full_n[0]), 32'd0);
    for (int i = 0; i < 4; i++) pop(0);
    check("drain empty_n", 32'(empty_n[0]), 32'd0);

    // 3. Steady read+write at count=2 across pointer wrap.
    push(0, 8'h50);
    push(0, 8'h51);
    for (int i = 0; i < 10; i++) begin
      idle();
      write[0] = 1'b1;
      read[0]  = 1'b1;
      din[0]   = DW'(8'h60 + i);
      tick();
      check("rw count", 32'(count[0]), 32'd2);
    end
    pop(0);
    pop(0);
    // Read+write at empty: only the write lands, no underflow.
    idle();
    write[0] = 1'b1;
    read[0]  = 1'b1;
    din[0]   = 8'h77;
    tick();
    check("rw@empty count", 32'(count[0]), 32'd1);
    check("rw@empty err_udf", 32'(err_udf[0]), 32'd0);
    pop(0);

    // 4. Overflow and underflow stick; contents survive the rejected write.
    for (int i = 0; i < 4; i++) push(0, DW'(8'hA0 + i));
    push(0, 8'hEE);
    check("ovf set", 32'(err_ovf[0]), 32'd1);
    for (int i = 0; i < 4; i++) pop(0);
    pop(0);
    check("udf set", 32'(err_udf[0]), 32'd1);
    check("ovf sticky", 32'(err_ovf[0]), 32'd1);
    idle();
    flush[0] = 1'b1;
    tick();
    check("flush clears ovf", 32'(err_ovf[0]), 32'd0);
    check("flush clears udf", 32'(err_udf[0]), 32'd0);

    // 5. Flush beats a same-cycle write on ch1; ch0 is unaffected.
    push(1, 8'hB1);
    push(1, 8'hB2);
    push(1, 8'hB3);
    idle();
    flush[1] = 1'b1;
    write[1] = 1'b1;
    din[1]   = 8'h55;
    write[0] = 1'b1;
    din[0]   = 8'hAA;
    tick();
    check("flush ch1 count", 32'(count[1]), 32'd0);
    check("flush ch1 empty_n", 32'(empty_n[1]), 32'd0);
    check("flush ch1 err_ovf", 32'(err_ovf[1]), 32'd0);
    check("ch0 count", 32'(count[0]), 32'd1);
    check("ch0 dout", 32'(dout[0]), 32'hAA);

    // 6. Reset mid-traffic with a write pending at count=3.
    push(0, 8'hC1);
    push(0, 8'hC2);
    check("pre-reset count", 32'(count[0]), 32'd3);
    idle();
    write[0] = 1'b1;
    din[0]   = 8'hDD;
    arst_n   = 1'b0;
    tick();
    check("reset count", 32'(count[0]), 32'd0);
    arst_n = 1'b1;
    idle();
    tick();
    check("reset write dropped", 32'(empty_n[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
